// File: rtl/glitch_free_demux_if.sv
// Stream bundle for the 1-to-N demux: one upstream valid/ready input,
// N registered downstream outputs, and the drop counter.
interface glitch_free_demux_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = $clog2(N);

  logic [SW-1:0]  select;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_last;
  logic           in_ready;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_last;
  logic [N-1:0]   out_ready;
  logic [7:0]     drop_count;

  // The source of traffic and sink of all output streams.
  modport master (
    output select, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, drop_count
  );

  // The demux itself.
  modport slave (
    input  select, in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, drop_count
  );
endinterface

// File: rtl/glitch_free_demux.sv
// Packet-oriented 1-to-N stream demux with registered, glitch-free outputs.
// The route is latched on a packet's first beat and held until in_last.
module glitch_free_demux #(
  parameter int N = 4,
  parameter int W = 8
) (
  input logic              clk,
  input logic              rst,
  glitch_free_demux_if.slave bus
);
  localparam int SW = $clog2(N);
  localparam logic [SW:0] N_EXT = (SW+1)'(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t              state;
  logic [SW-1:0]       sel_q;
  logic [SW-1:0]       sel_eff;
  logic                bad;
  logic                xfer;
  logic                tgt_busy;
  logic                in_ready;
  logic [N-1:0]        load;
  logic [7:0]          drop_q;
  logic [N-1:0][W-1:0] data_q;
  logic [N-1:0]        valid_q;
  logic [N-1:0]        last_q;

  // NOTE: every variable written here gets a default before any branch so
  // that no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_eff  = (state == IDLE) ? bus.select : sel_q;
    bad      = (state == DROP) ||
               ((state == IDLE) && ({1'b0, bus.select} >= N_EXT));
    tgt_busy = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (sel_eff == SW'(k)) tgt_busy = valid_q[k] & ~bus.out_ready[k];
    end
    // Only the targeted output can stall the input; dropped beats never stall.
    in_ready = bad | ~tgt_busy;
    xfer     = bus.in_valid & in_ready;
    load     = '0;
    for (int k = 0; k < N; k++) begin
      load[k] = xfer & ~bad & (sel_eff == SW'(k));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      sel_q  <= '0;
      drop_q <= '0;
    end else if (xfer) begin
      if (state == IDLE) begin
        if (bad && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
        if (!bus.in_last) begin
          sel_q <= bus.select;
          state <= bad ? DROP : ROUTE;
        end
      end else if (bus.in_last) begin
        state <= IDLE;
      end
    end
  end

  // NOTE: the data/last registers are reset too, because their zero value
  // after reset is visible on the outputs, not just a don't-care.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      last_q  <= '0;
      valid_q <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (load[k]) begin
          data_q[k]  <= bus.in_data;
          last_q[k]  <= bus.in_last;
          valid_q[k] <= 1'b1;
        end else if (bus.out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_data   = data_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_last   = last_q;
  assign bus.drop_count = drop_q;
endmodule

// File: doc/glitch_free_demux.md
Name: glitch_free_demux

Overview:
- Packet-oriented 1-to-N stream demultiplexer; the routing counterpart of the 2:1 select mux used in the combinational-logic examples.
- Steers valid/ready beats from one input stream to one of N output streams.
- Every output is driven from a register, so `select` and input changes never reach an output combinationally. Outputs are therefore glitch-free.
- The route is latched on the first beat of a packet and held until `in_last`.

Parameters:
- N, 4, number of output streams (≥2).
- W, 8, data width in bits.
- SW, $clog2(N), select width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- select  input  SW  destination index; sampled only on the first beat of a packet.
- in_data  input  W  input beat data.
- in_valid  input  1  input beat valid.
- in_last  input  1  marks the final beat of a packet.
- in_ready  output  1  input may transfer this cycle.
- out_data  output  N*W  flattened; slice k is bits [k*W +: W].
- out_valid  output  N  per-output valid.
- out_last  output  N  per-output last-beat flag.
- out_ready  input  N  per-output downstream ready.
- drop_count  output  8  saturating count of packets dropped for an out-of-range select.

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid=0, out_last=0, out_data=0 for all k.
  - state=IDLE, sel_q=0, drop_count=0.
  - A packet in flight is abandoned; after release the next accepted beat is treated as a first beat.
- States: IDLE (awaiting first beat), ROUTE (mid-packet, forwarding to sel_q), DROP (mid-packet, discarding).
- Effective select: sel_eff = select in IDLE, sel_q otherwise.
- Invalid selection: bad = (sel_eff ≥ N) in IDLE, or state==DROP.
- in_ready:
  - 1 when bad.
  - Otherwise ~out_valid[sel_eff] | out_ready[sel_eff].
  - This is combinational; it is the only combinational output.
- Transfer: xfer = in_valid & in_ready.
- Transitions:
  - IDLE, xfer, !in_last: sel_q←select; go to DROP if bad, else ROUTE.
  - IDLE, xfer, in_last (single-beat packet): stay in IDLE.
  - ROUTE or DROP, xfer with in_last: go to IDLE.
  - No xfer: hold state.
- drop_count increments by 1 on every first-beat xfer with bad. It saturates at 255 and never wraps.
- Output register k:
  - Load when xfer & !bad & sel_eff==k: out_data[k]←in_data, out_last[k]←in_last, out_valid[k]←1.
  - Otherwise, if out_ready[k]: out_valid[k]←0; out_data and out_last hold their last value.
  - Load with out_ready[k] high in the same cycle (pass-through at full rate): the new beat wins and out_valid stays 1.
- Latency: accepted beat appears at its output on the next rising edge (1 cycle). Throughput is 1 beat/cycle when downstream is always ready.
- Stability rules:
  - out_data[k] and out_last[k] change only on a load of k.
  - Non-selected outputs never toggle.
  - Changing `select` mid-packet has no effect on routing.
- Dropped beats never assert any out_valid.
- Outputs other than sel_eff do not influence in_ready. A stalled idle output does not block traffic to other outputs.

Test Plan (N=3, W=8 unless noted):
- Reset: hold rst=0 with in_valid=1, out_ready=0 → in_ready is don't-care; all out_valid=0, out_data=0, drop_count=0. Release → first beat with select=1 lands at out_data[15:8] one cycle later.
- Packet routing:
  - Stimulus: select=2; beats 0xA1, 0xA2, 0xA3(last); flip select to 0 after beat 1; out_ready=3'b111.
  - Required: all three beats appear on output 2 on consecutive cycles; out_last[2] is set on 0xA3 only; outputs 0 and 1 stay constant.
- Backpressure:
  - Stimulus: select=0; out_ready[0]=0; send 0x11, 0x22.
  - Required: 0x11 loads, then in_ready=0 and 0x22 is held.
  - Raise out_ready[0] → 0x22 accepted the same cycle and visible next cycle; no beat lost or duplicated.
- Drop:
  - Stimulus: select=3, two-beat packet.
  - Required: in_ready=1, no out_valid rises, drop_count=1.
  - Run 300 invalid single-beat packets → drop_count=255.
- Reset mid-packet:
  - Stimulus: after the first beat of a 3-beat packet to output 1, pulse rst=0 for 1 cycle.
  - Required: state returns to IDLE; next beat with select=0 routes to output 0.
- Independence: out_valid[1]=1 with out_ready[1]=0 → a single-beat packet to output 0 still transfers (in_ready=1); output 1 holds its data unchanged.
